// File: rtl/align_shift_right.sv
// align_shift_right: five-stage pipelined right shifter with sticky collapse for fp_adder operand alignment
module align_shift_right #(
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      mant_in,
  input  logic [7:0]       shift_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [26:0]      mant_out,
  output logic [TAG_W-1:0] tag_out
);
  logic                  en;
  logic [4:0]            v_q, v_d, vi;
  logic [4:0][26:0]      m_q, m_d, mi;
  logic [4:0][4:0]       a_q, a_d, ai;
  logic [4:0][TAG_W-1:0] t_q, t_d, ti;
  assign en = ~v_q[4] | out_ready;
  assign vi = {v_q[3:0], in_valid};
  assign mi = {m_q[3:0], {mant_in, 3'b000}};
  assign ai = {a_q[3:0], shift_in >= 8'd32 ? 5'd31 : shift_in[4:0]};
  assign ti = {t_q[3:0], tag_in};
  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int S = 16 >> i;
    logic [26:0] sh;
    assign sh = mi[i] >> S;
    assign m_d[i] = !en ? m_q[i] : ai[i][4-i] ? {sh[26:1], sh[0] | (|mi[i][S-1:0])} : mi[i];
  end
  always_comb begin
    v_d = en ? vi : v_q;
    a_d = en ? ai : a_q;
    t_d = en ? ti : t_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      m_q <= '0;
      a_q <= '0;
      t_q <= '0;
    end else begin
      v_q <= v_d;
      m_q <= m_d;
      a_q <= a_d;
      t_q <= t_d;
    end
  end
  assign in_ready  = en;
  assign out_valid = v_q[4];
  assign mant_out  = m_q[4];
  assign tag_out   = t_q[4];
endmodule
